// File: rtl/definitions_pkg.sv
// Shared types for the UART pixel framer: parser states, FIFO entry layout, default sync marker.
// FRAMER_CHECKSUM_EN adds the CHECK state used for the trailing XOR byte.
package definitions_pkg;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_LEN_HI,
      ST_LEN_LO,
`ifdef FRAMER_CHECKSUM_EN
      ST_PAYLOAD,
      ST_CHECK
`else
      ST_PAYLOAD
`endif
   } parser_state_t;

   typedef struct packed {
      logic       last;
      logic [7:0] dat;
   } pix_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; head is read combinationally, no fall-through.
// Push while full is accepted only when a pop happens in the same cycle, otherwise it is dropped.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             wr_en;
   logic             rd_en;

   // The extra MSB on each pointer separates full from empty when the indices match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_en   = pop && !empty;
   assign wr_en   = push && (!full || rd_en);
   assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/uart_pixel_framer.sv
// Parses SYNC/LEN_HI/LEN_LO/payload frames from a UART byte stream into a pixel FIFO; FRAMER_CHECKSUM_EN adds a trailing XOR byte.
// One cycle rx_done-to-pix_valid; the UART side cannot stall, so a full FIFO drops the byte and pulses overrun.
module uart_pixel_framer
   import definitions_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic [7:0] pix_data,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic       pix_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       overrun
);

   parser_state_t state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          ok_q, ok_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q;
`ifdef FRAMER_CHECKSUM_EN
   logic [7:0]    acc_q, acc_d;
`endif

   logic          push;
   logic          push_last;
   logic          drop;
   logic          fifo_full;
   logic          fifo_empty;
   pix_entry_t    push_entry;
   pix_entry_t    head_entry;

   // A pop frees a slot in the same cycle, so only a stalled full FIFO loses a byte.
   assign drop = rx_done && (state_q == ST_PAYLOAD) && fifo_full && !pix_ready;
   assign push_entry = {push_last, rx_data};

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(pix_entry_t))
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (push_entry),
      .pop      (pix_ready),
      .pop_dat  (head_entry),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // The head slot is never reset, so mask it while empty.
   assign pix_valid = !fifo_empty;
   assign pix_data  = fifo_empty ? 8'h00 : head_entry.dat;
   assign pix_last  = fifo_empty ? 1'b0  : head_entry.last;
   assign frame_ok  = ok_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      ok_d      = 1'b0;
      ferr_d    = 1'b0;
      push      = 1'b0;
      push_last = 1'b0;
`ifdef FRAMER_CHECKSUM_EN
      acc_d     = acc_q;
`endif
      if (rx_done) begin
         case (state_q)
            ST_HUNT: begin
               if (rx_data == SYNC_BYTE) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
               len_d[15:8] = rx_data;
               state_d     = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               len_d[7:0] = rx_data;
               if ({len_q[15:8], rx_data} == 16'd0) begin
                  ferr_d  = 1'b1;
                  state_d = ST_HUNT;
               end else begin
                  cnt_d   = 16'd0;
                  err_d   = 1'b0;
`ifdef FRAMER_CHECKSUM_EN
                  acc_d   = 8'h00;
`endif
                  state_d = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               push      = 1'b1;
               push_last = (cnt_q == len_q - 16'd1);
               cnt_d     = cnt_q + 16'd1;
               if (drop) err_d = 1'b1;
`ifdef FRAMER_CHECKSUM_EN
               acc_d = acc_q ^ rx_data;
               if (push_last) state_d = ST_CHECK;
`else
               if (push_last) begin
                  ok_d    = !(err_q || drop);
                  ferr_d  = err_q || drop;
                  state_d = ST_HUNT;
               end
`endif
            end
`ifdef FRAMER_CHECKSUM_EN
            ST_CHECK: begin
               ok_d    = (rx_data == acc_q) && !err_q;
               ferr_d  = !((rx_data == acc_q) && !err_q);
               state_d = ST_HUNT;
            end
`endif
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HUNT;
         len_q   <= 16'd0;
         cnt_q   <= 16'd0;
         err_q   <= 1'b0;
         ok_q    <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef FRAMER_CHECKSUM_EN
         acc_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ok_q    <= ok_d;
         ferr_q  <= ferr_d;
         ovr_q   <= drop;
`ifdef FRAMER_CHECKSUM_EN
         acc_q   <= acc_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_pixel_framer.sv
// Directed bench for uart_pixel_framer (FIFO_DEPTH=4); follows FRAMER_CHECKSUM_EN for the CHK byte.
module tb_uart_pixel_framer;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [7:0] pix_data;
   logic       pix_valid;
   logic       pix_ready;
   logic       pix_last;
   logic       frame_ok;
   logic       frame_err;
   logic       overrun;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor state (written only by the negedge monitor)
   logic [8:0] rx_log [$];
   int         ok_cnt   = 0;
   int         err_cnt  = 0;
   int         ovr_cnt  = 0;
   int         both_cnt = 0;
   int         hold_bad = 0;
   logic       prev_hold = 1'b0;
   logic [8:0] prev_head = 9'h000;

   // Per-test baselines (written only by the main process)
   int rd_idx = 0;
   int ok0, err0, ovr0;

   uart_pixel_framer #(
      .FIFO_DEPTH (4),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_last  (pix_last),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (pix_valid && pix_ready) rx_log.push_back({pix_last, pix_data});
         if (frame_ok) ok_cnt++;
         if (frame_err) err_cnt++;
         if (overrun) ovr_cnt++;
         if (frame_ok && frame_err) both_cnt++;
         if (prev_hold && (!pix_valid || {pix_last, pix_data} != prev_head)) hold_bad++;
         prev_hold = pix_valid && !pix_ready;
         prev_head = {pix_last, pix_data};
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick(1);
      rx_done = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic mark();
      ok0    = ok_cnt;
      err0   = err_cnt;
      ovr0   = ovr_cnt;
      rd_idx = rx_log.size();
   endtask

   task automatic expect_pix(input string tag, input logic [8:0] exp);
      logic [8:0] got;
      got = (rd_idx < rx_log.size()) ? rx_log[rd_idx] : 9'h1FF;
      check(tag, {23'd0, got}, {23'd0, exp});
      rd_idx++;
   endtask

   initial begin
      rst       = 1'b1;
      rx_done   = 1'b0;
      rx_data   = 8'h00;
      pix_ready = 1'b0;
      tick(3);
      check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      check("rst_pix_data",  {24'd0, pix_data},  32'd0);
      check("rst_pix_last",  {31'd0, pix_last},  32'd0);
      check("rst_frame_ok",  {31'd0, frame_ok},  32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_overrun",   {31'd0, overrun},   32'd0);
      rst = 1'b0;
      tick(2);

      // Basic 3-byte frame, consumer always ready
      mark();
      pix_ready = 1'b1;
      send(8'hA5); send(8'h00); send(8'h03);
      check("t1_idle_valid", {31'd0, pix_valid}, 32'd0);
      send(8'h11);
      check("t1_latency_valid", {31'd0, pix_valid}, 32'd1);
      check("t1_latency_data",  {24'd0, pix_data},  32'h11);
      send(8'h22); send(8'h33);
`ifdef FRAMER_CHECKSUM_EN
      send(8'h00);
`endif
      check("t1_ok_pulse", {31'd0, frame_ok}, 32'd1);
      tick(4);
      expect_pix("t1_pix0", 9'h011);
      expect_pix("t1_pix1", 9'h022);
      expect_pix("t1_pix2", 9'h133);
      check("t1_ok_count",  ok_cnt - ok0,   32'd1);
      check("t1_err_count", err_cnt - err0, 32'd0);

      // AA 55 with CHK 00: bad checksum when enabled; otherwise 00 is idle garbage
      mark();
      send(8'hA5); send(8'h00); send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
      tick(4);
      expect_pix("t2_pix0", 9'h0AA);
      expect_pix("t2_pix1", 9'h155);
`ifdef FRAMER_CHECKSUM_EN
      check("t2_ok_count",  ok_cnt - ok0,   32'd0);
      check("t2_err_count", err_cnt - err0, 32'd1);
`else
      check("t2_ok_count",  ok_cnt - ok0,   32'd1);
      check("t2_err_count", err_cnt - err0, 32'd0);
`endif

      // Zero-length frame, then a normal one
      mark();
      send(8'hA5); send(8'h00); send(8'h00);
      check("t3_zero_err_pulse", {31'd0, frame_err}, 32'd1);
      tick(1);
      check("t3_zero_err_single", {31'd0, frame_err}, 32'd0);
      check("t3_zero_fifo_empty", {31'd0, pix_valid}, 32'd0);
      send(8'hA5); send(8'h00); send(8'h01); send(8'h7E);
`ifdef FRAMER_CHECKSUM_EN
      send(8'h7E);
`endif
      tick(3);
      expect_pix("t3_pix0", 9'h17E);
      check("t3_ok_count",  ok_cnt - ok0,   32'd1);
      check("t3_err_count", err_cnt - err0, 32'd1);

      // Overrun: 6 bytes into a 4-deep FIFO with the consumer stalled
      mark();
      pix_ready = 1'b0;
      send(8'hA5); send(8'h00); send(8'h06);
      for (int i = 1; i <= 6; i++) send(i[7:0]);
`ifdef FRAMER_CHECKSUM_EN
      send(8'h07);
`endif
      tick(2);
      check("t4_hold_data",  {24'd0, pix_data}, 32'h01);
      check("t4_ovr_count",  ovr_cnt - ovr0, 32'd2);
      check("t4_err_count",  err_cnt - err0, 32'd1);
      check("t4_ok_count",   ok_cnt - ok0,   32'd0);
      pix_ready = 1'b1;
      tick(8);
      for (int i = 1; i <= 4; i++) expect_pix("t4_drain", {1'b0, i[7:0]});
      check("t4_drained", {31'd0, pix_valid}, 32'd0);

      // Push and pop together while full: no loss
      mark();
      pix_ready = 1'b0;
      send(8'hA5); send(8'h00); send(8'h05);
      send(8'h11); send(8'h12); send(8'h13); send(8'h14);
      pix_ready = 1'b1;
      send(8'h15);
`ifdef FRAMER_CHECKSUM_EN
      send(8'h11);
`endif
      tick(8);
      expect_pix("t4b_pix0", 9'h011);
      expect_pix("t4b_pix1", 9'h012);
      expect_pix("t4b_pix2", 9'h013);
      expect_pix("t4b_pix3", 9'h014);
      expect_pix("t4b_pix4", 9'h115);
      check("t4b_ovr_count", ovr_cnt - ovr0, 32'd0);
      check("t4b_ok_count",  ok_cnt - ok0,   32'd1);

      // Leading garbage before a valid frame
      mark();
      send(8'h00); send(8'hFF); send(8'hA4);
      send(8'hA5); send(8'h00); send(8'h01); send(8'h5A);
`ifdef FRAMER_CHECKSUM_EN
      send(8'h5A);
`endif
      tick(3);
      expect_pix("t5_pix0", 9'h15A);
      check("t5_ok_count",  ok_cnt - ok0,   32'd1);
      check("t5_err_count", err_cnt - err0, 32'd0);

      // Reset mid-frame, with an rx_done landing during reset
      mark();
      pix_ready = 1'b0;
      send(8'hA5); send(8'h00); send(8'h05); send(8'hB1); send(8'hB2);
      check("t6_pre_valid", {31'd0, pix_valid}, 32'd1);
      rst = 1'b1;
      tick(1);
      check("t6_rst_valid", {31'd0, pix_valid}, 32'd0);
      check("t6_rst_data",  {24'd0, pix_data},  32'd0);
      rx_data = 8'hA5;
      rx_done = 1'b1;
      tick(1);
      rx_done = 1'b0;
      rst     = 1'b0;
      send(8'h00); send(8'h01); send(8'hC3);
      tick(2);
      check("t6_ignored_sync", {31'd0, pix_valid}, 32'd0);
      check("t6_no_pulse", (ok_cnt - ok0) + (err_cnt - err0), 32'd0);
      pix_ready = 1'b1;
      send(8'hA5); send(8'h00); send(8'h01); send(8'hC4);
`ifdef FRAMER_CHECKSUM_EN
      send(8'hC4);
`endif
      tick(3);
      expect_pix("t6_pix0", 9'h1C4);
      check("t6_ok_count",  ok_cnt - ok0,   32'd1);
      check("t6_err_count", err_cnt - err0, 32'd0);

      check("never_both_pulses", both_cnt, 32'd0);
      check("stall_hold",        hold_bad, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
